// File: rtl/clock_ctrl_pkg.sv
// Shared types and BCD helpers for the time-set controller.
// Hours run 00..11, minutes 00..59, one BCD digit per nibble.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_SET_HR  = 2'b01,
      ST_SET_MIN = 2'b10,
      ST_COMMIT  = 2'b11
   } state_t;

   localparam logic [7:0] HOUR_MAX     = 8'd11;
   localparam logic [3:0] MIN_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;

   typedef struct packed {
      logic [3:0] h2;
      logic [3:0] h1;
      logic [3:0] m2;
      logic [3:0] m1;
   } hm_t;

   function automatic logic [7:0] hour_bin(input logic [7:0] h);
      return {4'd0, h[7:4]} * 8'd10 + {4'd0, h[3:0]};
   endfunction

   function automatic logic hour_ok(input logic [7:0] h);
      return (h[7:4] <= 4'd1) && (h[3:0] <= DIGIT_MAX) &&
             (hour_bin(h) <= HOUR_MAX);
   endfunction

   function automatic logic min_ok(input logic [7:0] m);
      return (m[7:4] <= MIN_TENS_MAX) && (m[3:0] <= DIGIT_MAX);
   endfunction

   function automatic logic [7:0] hour_inc(input logic [7:0] h);
      if (hour_bin(h) >= HOUR_MAX)
         return 8'h00;
      else if (h[3:0] >= DIGIT_MAX)
         return {h[7:4] + 4'd1, 4'd0};
      else
         return {h[7:4], h[3:0] + 4'd1};
   endfunction

   // Minutes wrap 59 -> 00 on their own; hours are never touched.
   function automatic logic [7:0] min_inc(input logic [7:0] m);
      if (m[3:0] >= DIGIT_MAX) begin
         if (m[7:4] >= MIN_TENS_MAX)
            return 8'h00;
         else
            return {m[7:4] + 4'd1, 4'd0};
      end else begin
         return {m[7:4], m[3:0] + 4'd1};
      end
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debouncer
// and a registered one-cycle pulse on each accepted press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          level_dly_q;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         cnt_q       <= '0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= btn;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
         press_q     <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: RUN/SET_HR/SET_MIN/COMMIT sequencing, BCD edit
// registers, one-cycle load to the time counter and field blink masks.
module time_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int BLINK_CYCLES    = 2000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hour2,
   input  logic [3:0] cur_hour1,
   input  logic [3:0] cur_min2,
   input  logic [3:0] cur_min1,
   output logic       count_en,
   output logic       load,
   output logic [3:0] load_hour2,
   output logic [3:0] load_hour1,
   output logic [3:0] load_min2,
   output logic [3:0] load_min1,
   output logic [1:0] blink_mask,
   output logic [1:0] mode
);

   localparam int BW = $clog2(BLINK_CYCLES + 1);

   logic          mode_p, inc_p;
   state_t        state_q, state_d;
   hm_t           edit_q, edit_d;
   logic          count_en_q, count_en_d;
   logic          load_q, load_d;
   logic [1:0]    mask_q, mask_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          inc_acc;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_mode),
      .press (mode_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_inc),
      .press (inc_p)
   );

   always_comb begin
      state_d = state_q;
      edit_d  = edit_q;
      inc_acc = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (mode_p) begin
               state_d = ST_SET_HR;
               {edit_d.h2, edit_d.h1} = hour_ok({cur_hour2, cur_hour1}) ?
                  {cur_hour2, cur_hour1} : 8'h00;
               {edit_d.m2, edit_d.m1} = min_ok({cur_min2, cur_min1}) ?
                  {cur_min2, cur_min1} : 8'h00;
            end
         end
         ST_SET_HR: begin
            if (mode_p) begin
               state_d = ST_SET_MIN;
            end else if (inc_p) begin
               {edit_d.h2, edit_d.h1} = hour_inc({edit_q.h2, edit_q.h1});
               inc_acc = 1'b1;
            end
         end
         ST_SET_MIN: begin
            if (mode_p) begin
               state_d = ST_COMMIT;
            end else if (inc_p) begin
               {edit_d.m2, edit_d.m1} = min_inc({edit_q.m2, edit_q.m1});
               inc_acc = 1'b1;
            end
         end
         ST_COMMIT: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase

      // Restart the visible half-period whenever the user acts.
      if ((state_d != state_q) || inc_acc) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end else begin
         bcnt_d  = bcnt_q + BW'(1);
         phase_d = phase_q;
      end

      count_en_d = (state_d == ST_RUN);
      load_d     = (state_d == ST_COMMIT);
      mask_d     = {(state_d == ST_SET_HR) & phase_d,
                    (state_d == ST_SET_MIN) & phase_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         edit_q     <= '0;
         count_en_q <= 1'b1;
         load_q     <= 1'b0;
         mask_q     <= 2'b00;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         edit_q     <= edit_d;
         count_en_q <= count_en_d;
         load_q     <= load_d;
         mask_q     <= mask_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
      end
   end

   assign count_en   = count_en_q;
   assign load       = load_q;
   assign load_hour2 = edit_q.h2;
   assign load_hour1 = edit_q.h1;
   assign load_min2  = edit_q.m2;
   assign load_min1  = edit_q.m1;
   assign blink_mask = mask_q;
   assign mode       = state_q;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Controller that sequences the 12-hour time counter between normal counting and user time-set mode. It debounces two push-buttons, runs a RUN/SET_HR/SET_MIN/COMMIT state machine, and edits BCD hour and minute values. It then issues a single-cycle load to the time counter, with seconds cleared by the counter on load. It also drives per-field blink masks so the display multiplexer can flash the field being edited.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive stable synchronized cycles needed to accept a new button level
BLINK_CYCLES, 2000000, clk cycles per blink half-period

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
cur_hour2  in  4  live time, hour tens, BCD
cur_hour1  in  4  live time, hour units, BCD
cur_min2  in  4  live time, minute tens, BCD
cur_min1  in  4  live time, minute units, BCD
count_en  out  1  enable to the time counter
load  out  1  one-cycle load strobe to the time counter
load_hour2  out  4  edited hour tens value
load_hour1  out  4  edited hour units value
load_min2  out  4  edited minute tens value
load_min1  out  4  edited minute units value
blink_mask  out  2  [1] blank hours field, [0] blank minutes field
mode  out  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 COMMIT

Behaviour:
- Outputs: all registered.
- Reset (rst_n low, any time including mid-edit):
  - state RUN, count_en=1, load=0, all load_*=0, blink_mask=00, mode=00.
  - An edit in progress is abandoned and no load is issued.
- Buttons: each passes through a 2-FF synchronizer and then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreement before that clears the debounce counter.
  - A press is a one-cycle pulse, registered, in the cycle after the debounced level rises. Release generates nothing.
- RUN:
  - count_en=1.
  - mode press -> capture cur_* into the edit registers, go to SET_HR.
  - Capture sanitizing: any captured hour above 11 or minute above 59 (non-BCD digit included) loads 00 for that field.
  - inc press is ignored.
- SET_HR:
  - count_en=0.
  - inc press -> hours +1 in BCD: 00..09 -> next, 09 -> 10, 10 -> 11, 11 -> 00.
  - mode press -> SET_MIN.
- SET_MIN:
  - count_en=0.
  - inc press -> minutes +1 in BCD: units 9 -> 0 with tens +1; 59 -> 00, no carry into hours.
  - mode press -> COMMIT.
- COMMIT:
  - Lasts exactly one cycle: load=1, count_en=0, load_* hold the edited values.
  - Next cycle: RUN, load=0, count_en=1.
- Timing: the state update is visible the cycle after the press pulse.
- load_* continuously reflect the edit registers, so the display can show values being edited.
- Simultaneous mode and inc pulses in the same cycle: mode wins, inc is discarded.
- Blink:
  - A phase counter counts to BLINK_CYCLES-1 and then toggles phase.
  - Counter and phase clear to visible (phase=0) on every state entry and on every accepted inc press.
  - blink_mask[1] = phase in SET_HR, blink_mask[0] = phase in SET_MIN, else 0.
- Edit registers are 4-bit BCD and never leave the ranges 00..11 (hours) and 00..59 (minutes).

Decomposition:
- Package clock_ctrl_pkg:
  - state encoding constants ST_RUN, ST_SET_HR, ST_SET_MIN, ST_COMMIT.
  - HOUR_MAX=11, MIN_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module btn_debounce (synchronizer + stable counter + rise-edge pulse, parameter DEBOUNCE_CYCLES), instantiated for btn_mode and btn_inc.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.)
1. Reset low, then high -> mode=00, count_en=1, load=0, load_*=0, blink_mask=00. Pulse btn_mode 2 cycles only -> no state change (debounce rejects).
2. cur time 10:58, hold mode -> mode=01, load_* = 1,0,5,8, count_en=0. Three inc presses -> hours 11, 00, 01.
3. In SET_MIN with 01:58, two inc presses -> 01:59, then 01:00; hours stay 01. Mode press -> exactly one cycle mode=11 with load=1, load_* = 0,1,0,0, then mode=00, count_en=1.
4. In SET_HR, assert mode and inc on the same cycle -> mode=10, hours unchanged. In SET_MIN, drop rst_n mid-edit -> mode=00, load never asserted.
5. In SET_HR, wait -> blink_mask toggles 00/10 every 8 cycles, starting visible on entry. An inc press restarts the visible phase.
6. cur time 13:7A (invalid), mode press -> load_* = 0,0,0,0. inc press in RUN -> no change.
